stress_sample_tx: RTL and testbench



---
 rtl/stress_pkg.sv | 6 +
 rtl/sample_fifo.sv | 45 ++++
 rtl/stress_sample_tx.sv | 98 +++++++++
 tb/tb_stress_sample_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stress_pkg.sv
// stress_pkg: shared FSM state type and default link constants for the stress-sensor serial link
package stress_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int CLK_DIV_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 4;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: power-of-2 sync FIFO; in clk, rst_n, push_i, pop_i, wr_data_i; out rd_data_o (head), full_o, empty_o, level_o
module sample_fifo
  import stress_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wr_data_i,
  output logic [W-1:0]             rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] level_q, level_d;
  always_comb begin
    wp_d = wp_q + AW'(push_i);
    rp_d = rp_q + AW'(pop_i);
    level_d = level_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= wr_data_i;
  end
  assign rd_data_o = mem_q[rp_q];
  assign full_o = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
endmodule

// File: rtl/stress_sample_tx.sv
// stress_sample_tx: FIFO-buffered 8N1 UART sender (opt. even parity); in clk, rst_n, ena, sample_data/valid, clr_ovf; out sample_ready, tx, tx_busy, fifo_level, overflow
module stress_sample_tx
  import stress_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    sample_data,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int CW = $clog2(CLK_DIV);
  tx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, head;
  logic par_q, par_d, tx_q, tx_d, ovf_q, ovf_d;
  logic full, empty, push, pop, tick, start_ok;
  assign push = sample_valid && !full;
  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .pop_i     (pop),
    .wr_data_i (sample_data),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (fifo_level)
  );
  always_comb begin
    tick = cnt_q == CW'(CLK_DIV - 1);
    start_ok = !empty && ena;
    pop = 1'b0;
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    cnt_d = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        pop = start_ok;
        state_d = start_ok ? START : IDLE;
      end
      START: state_d = tick ? DATA : START;
      DATA: if (tick) begin
        sh_d = sh_q >> 1;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
      end
      PARITY: state_d = tick ? STOP : PARITY;
      STOP: if (tick) begin
        pop = start_ok;
        state_d = start_ok ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      sh_d = head;
      par_d = ^head;
    end
    // tx is registered, so it is derived from the state being entered
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : (state_d == PARITY) ? par_q : 1'b1;
    ovf_d = (sample_valid && full) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      par_q <= par_d;
      tx_q <= tx_d;
      ovf_q <= ovf_d;
    end
  end
  assign tx = tx_q;
  assign tx_busy = state_q != IDLE;
  assign sample_ready = !full;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_stress_sample_tx.sv
// tb_stress_sample_tx: checks two instances (no parity / even parity) against a frame-level reference model
module tb_stress_sample_tx;
  localparam int CD = 4;
  localparam int DP = 4;
  localparam int HN = 1000;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ena = 1'b0;
  logic sample_valid = 1'b0;
  logic clr_ovf = 1'b0;
  logic [7:0] sample_data = 8'h00;
  logic rdy [2];
  logic txo [2];
  logic bsy [2];
  logic ovo [2];
  logic [2:0] lvl [2];
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mq [2][$];
  logic [10:0] frm [2];
  int flen [2];
  int fcyc [2];
  logic movf [2];
  logic h_tx [2][HN];
  logic h_b [2][HN];
  typedef struct {
    logic v;
    logic [7:0] d;
    logic c;
    int lvl;
    logic rdy;
    logic ovf;
  } vec_t;
  vec_t tbl [7];
  always #5 clk = ~clk;
  stress_sample_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DP), .PARITY_EN(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(rdy[0]), .clr_ovf(clr_ovf), .tx(txo[0]), .tx_busy(bsy[0]), .fifo_level(lvl[0]),
    .overflow(ovo[0])
  );
  stress_sample_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DP), .PARITY_EN(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(rdy[1]), .clr_ovf(clr_ovf), .tx(txo[1]), .tx_busy(bsy[1]), .fifo_level(lvl[1]),
    .overflow(ovo[1])
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      fcyc[k] = -1;
      flen[k] = 10;
      frm[k] = '1;
      movf[k] = 1'b0;
    end
  endtask
  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      logic full;
      logic [7:0] d;
      full = mq[k].size() >= DP;
      if (sample_valid && full) movf[k] = 1'b1;
      else if (clr_ovf) movf[k] = 1'b0;
      if (fcyc[k] >= 0) begin
        fcyc[k]++;
        if (fcyc[k] == flen[k] * CD) fcyc[k] = -1;
      end
      if (fcyc[k] < 0 && mq[k].size() > 0 && ena) begin
        d = mq[k].pop_front();
        flen[k] = (k == 1) ? 11 : 10;
        frm[k] = (k == 1) ? {1'b1, ^d, d, 1'b0} : {2'b11, d, 1'b0};
        fcyc[k] = 0;
      end
      if (sample_valid && !full) mq[k].push_back(sample_data);
    end
  endtask
  task automatic m_check();
    for (int k = 0; k < 2; k++) begin
      logic etx;
      etx = (fcyc[k] < 0) ? 1'b1 : frm[k][fcyc[k] / CD];
      chk($sformatf("tx%0d", k), txo[k], etx);
      chk($sformatf("busy%0d", k), bsy[k], fcyc[k] >= 0);
      chk($sformatf("ready%0d", k), rdy[k], mq[k].size() < DP);
      chk($sformatf("level%0d", k), lvl[k], mq[k].size());
      chk($sformatf("ovf%0d", k), ovo[k], movf[k]);
    end
  endtask
  task automatic tick();
    if (rst_n) m_step();
    @(posedge clk);
    #1;
    m_check();
  endtask
  task automatic cap(input int n, input int clr_at);
    for (int i = 0; i < n && i < HN; i++) begin
      if (i == clr_at) sample_valid = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
        h_tx[k][i] = txo[k];
        h_b[k][i] = bsy[k];
      end
    end
  endtask
  function automatic int busy_cnt(input int k, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(h_b[k][i]);
    return c;
  endfunction
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int a5 [10];
    int sent;
    int idx;
    logic [7:0] b;
    logic [7:0] got [$];
    a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h12, 1'b0, 2, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h13, 1'b0, 3, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h14, 1'b0, 4, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h15, 1'b0, 4, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'h16, 1'b1, 4, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 4, 1'b0, 1'b0};
    m_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_tx", txo[k], 1);
      chk("rst_busy", bsy[k], 0);
      chk("rst_ready", rdy[k], 1);
      chk("rst_level", lvl[k], 0);
      chk("rst_ovf", ovo[k], 0);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    ena = 1'b1;
    sample_valid = 1'b1;
    sample_data = 8'hA5;
    tick();
    cap(45, 0);
    for (int i = 0; i < 10; i++) chk($sformatf("a5_bit%0d", i), h_tx[0][i * CD + 1], a5[i]);
    chk("a5_busy_cycles", busy_cnt(0, 45), 40);
    sample_valid = 1'b1;
    sample_data = 8'hA5;
    tick();
    sample_data = 8'h07;
    cap(96, 1);
    chk("par_a5", h_tx[1][37], 0);
    chk("par_gap_stop", h_tx[1][43], 1);
    chk("par_b2b_start", h_tx[1][44], 0);
    chk("par_07", h_tx[1][44 + 37], 1);
    chk("par_busy_cycles", busy_cnt(1, 96), 88);
    chk("nopar_busy_cycles", busy_cnt(0, 96), 80);
    ena = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample_valid = tbl[i].v;
      sample_data = tbl[i].d;
      clr_ovf = tbl[i].c;
      tick();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tbl%0d_level", i), lvl[k], tbl[i].lvl);
        chk($sformatf("tbl%0d_ready", i), rdy[k], tbl[i].rdy);
        chk($sformatf("tbl%0d_ovf", i), ovo[k], tbl[i].ovf);
      end
    end
    sample_valid = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    sample_valid = 1'b1;
    sample_data = 8'h3C;
    tick();
    sample_data = 8'hC3;
    tick();
    sample_valid = 1'b0;
    ena = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    ena = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("gate_tx_idle", txo[0], 1);
    chk("gate_busy", bsy[0], 0);
    chk("gate_level", lvl[0], 1);
    chk("gate_level_p", lvl[1], 1);
    ena = 1'b1;
    tick();
    chk("gate_restart_busy", bsy[0], 1);
    chk("gate_restart_tx", txo[0], 0);
    for (int i = 0; i < 17; i++) tick();
    chk("pre_rst_bit3", txo[0], 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_tx0", txo[0], 1);
    chk("async_rst_tx1", txo[1], 1);
    chk("async_rst_level", lvl[0], 0);
    chk("async_rst_busy", bsy[0], 0);
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    sample_valid = 1'b1;
    sample_data = 8'h5A;
    tick();
    cap(45, 0);
    chk("post_rst_busy_cycles", busy_cnt(0, 45), 40);
    sent = 0;
    for (int i = 0; i < 700; i++) begin
      sample_valid = (sent < 12) && rdy[0];
      sample_data = 8'(sent);
      tick();
      if (sample_valid) sent++;
      h_tx[0][i] = txo[0];
    end
    sample_valid = 1'b0;
    chk("wrap_sent", sent, 12);
    chk("wrap_ovf", ovo[0], 0);
    idx = 0;
    while (idx < 700 - 40) begin
      if (h_tx[0][idx] == 1'b0) begin
        for (int j = 0; j < 8; j++) b[j] = h_tx[0][idx + CD + j * CD + 1];
        chk("wrap_stop", h_tx[0][idx + 9 * CD + 1], 1);
        got.push_back(b);
        idx += 10 * CD;
      end else idx++;
    end
    chk("wrap_count", got.size(), 12);
    for (int j = 0; j < 12 && j < got.size(); j++) chk($sformatf("wrap_byte%0d", j), got[j], j);
    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(0, 2) == 0);
      sample_data = 8'($urandom);
      ena = ($urandom_range(0, 19) != 0);
      clr_ovf = ($urandom_range(0, 29) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
